// File: rtl/load_store_unit_if.sv
// Bundles the EX/MEM pipeline side and the data-memory side of the load/store unit.
// The LSU takes the master modport; the upstream stage and data memory take slave.
interface load_store_unit_if;
  // Pipeline side
  logic        valid_in;
  logic        memread;
  logic        memwrite;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [4:0]  rd_in;
  logic        stall;
  logic [31:0] rdata_out;
  logic [4:0]  rd_out;
  logic        load_valid;
  logic        fault;

  // Data-memory side
  logic        dmem_req;
  logic        dmem_we;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata;
  logic        dmem_ack;

  modport master (
    input  valid_in, memread, memwrite, funct3, addr, wdata, rd_in,
    output stall, rdata_out, rd_out, load_valid, fault,
    output dmem_req, dmem_we, dmem_be, dmem_addr, dmem_wdata,
    input  dmem_rdata, dmem_ack
  );

  modport slave (
    output valid_in, memread, memwrite, funct3, addr, wdata, rd_in,
    input  stall, rdata_out, rd_out, load_valid, fault,
    input  dmem_req, dmem_we, dmem_be, dmem_addr, dmem_wdata,
    output dmem_rdata, dmem_ack
  );
endinterface

// File: rtl/load_store_unit.sv
// Memory-stage load/store unit: req/ack data-memory transaction with byte-lane
// steering, load extension, pipeline stall and misalign/illegal/timeout faults.
module load_store_unit #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input logic               CLK,
  input logic               RESET,
  load_store_unit_if.master bus
);

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t           state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;

  // Attributes of the accepted access, needed when the ACK returns
  logic [2:0]  cap_funct3, cap_funct3_next;
  logic [1:0]  cap_off, cap_off_next;
  logic [4:0]  cap_rd, cap_rd_next;
  logic        cap_load, cap_load_next;

  // Registered outputs
  logic        req_r, req_next;
  logic        we_r, we_next;
  logic [3:0]  be_r, be_next;
  logic [31:0] daddr_r, daddr_next;
  logic [31:0] dwdata_r, dwdata_next;
  logic [31:0] rdata_r, rdata_next;
  logic [4:0]  rd_r, rd_next;
  logic        load_valid_r, load_valid_next;
  logic        fault_r, fault_next;

  // Request decode
  logic        op, is_store, legal, misaligned, accept, reject, timeout_hit;
  logic [3:0]  st_be;
  logic [31:0] st_wdata;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_ext;

  assign op       = bus.valid_in & (bus.memread | bus.memwrite);
  assign is_store = bus.memwrite;

  always_comb begin
    case (bus.funct3)
      3'b000, 3'b001, 3'b010: legal = 1'b1;
      3'b100, 3'b101:         legal = ~is_store;
      default:                legal = 1'b0;
    endcase
  end

  assign misaligned = ((bus.funct3[1:0] == 2'b01) & bus.addr[0]) |
                      ((bus.funct3[1:0] == 2'b10) & (|bus.addr[1:0]));

  assign accept      = (state == IDLE) & op & legal & ~misaligned;
  assign reject      = (state == IDLE) & op & ~(legal & ~misaligned);
  assign timeout_hit = (cnt == CNT_W'(TIMEOUT - 1));

  // Store data is replicated across lanes; the byte enables pick the real ones
  always_comb begin
    st_be    = 4'b1111;
    st_wdata = bus.wdata;
    case (bus.funct3[1:0])
      2'b00: begin
        st_be    = 4'b0001 << bus.addr[1:0];
        st_wdata = {4{bus.wdata[7:0]}};
      end
      2'b01: begin
        st_be    = bus.addr[1] ? 4'b1100 : 4'b0011;
        st_wdata = {2{bus.wdata[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    case (cap_off)
      2'b00:   ld_byte = bus.dmem_rdata[7:0];
      2'b01:   ld_byte = bus.dmem_rdata[15:8];
      2'b10:   ld_byte = bus.dmem_rdata[23:16];
      default: ld_byte = bus.dmem_rdata[31:24];
    endcase
    ld_half = cap_off[1] ? bus.dmem_rdata[31:16] : bus.dmem_rdata[15:0];
    case (cap_funct3)
      3'b000:  ld_ext = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  ld_ext = {{16{ld_half[15]}}, ld_half};
      3'b100:  ld_ext = {24'd0, ld_byte};
      3'b101:  ld_ext = {16'd0, ld_half};
      default: ld_ext = bus.dmem_rdata;
    endcase
  end

  // NOTE: every signal gets its hold value first so no path through the case infers a latch.
  always_comb begin
    state_next      = state;
    cnt_next        = cnt;
    cap_funct3_next = cap_funct3;
    cap_off_next    = cap_off;
    cap_rd_next     = cap_rd;
    cap_load_next   = cap_load;
    req_next        = req_r;
    we_next         = we_r;
    be_next         = be_r;
    daddr_next      = daddr_r;
    dwdata_next     = dwdata_r;
    rdata_next      = rdata_r;
    rd_next         = rd_r;
    load_valid_next = 1'b0;
    fault_next      = 1'b0;

    case (state)
      IDLE: begin
        if (accept) begin
          state_next      = ACCESS;
          cnt_next        = '0;
          req_next        = 1'b1;
          we_next         = is_store;
          be_next         = is_store ? st_be : 4'b1111;
          daddr_next      = {bus.addr[31:2], 2'b00};
          dwdata_next     = st_wdata;
          cap_funct3_next = bus.funct3;
          cap_off_next    = bus.addr[1:0];
          cap_rd_next     = bus.rd_in;
          cap_load_next   = ~is_store;
        end else if (reject) begin
          fault_next = 1'b1;
        end
      end
      ACCESS: begin
        if (bus.dmem_ack) begin
          state_next = IDLE;
          req_next   = 1'b0;
          if (cap_load) begin
            load_valid_next = 1'b1;
            rdata_next      = ld_ext;
            rd_next         = cap_rd;
          end
        end else if (timeout_hit) begin
          state_next = IDLE;
          req_next   = 1'b0;
          fault_next = 1'b1;
        end else begin
          cnt_next = cnt + CNT_W'(1);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state        <= IDLE;
      cnt          <= '0;
      cap_funct3   <= '0;
      cap_off      <= '0;
      cap_rd       <= '0;
      cap_load     <= 1'b0;
      req_r        <= 1'b0;
      we_r         <= 1'b0;
      be_r         <= '0;
      daddr_r      <= '0;
      dwdata_r     <= '0;
      rdata_r      <= '0;
      rd_r         <= '0;
      load_valid_r <= 1'b0;
      fault_r      <= 1'b0;
    end else begin
      state        <= state_next;
      cnt          <= cnt_next;
      cap_funct3   <= cap_funct3_next;
      cap_off      <= cap_off_next;
      cap_rd       <= cap_rd_next;
      cap_load     <= cap_load_next;
      req_r        <= req_next;
      we_r         <= we_next;
      be_r         <= be_next;
      daddr_r      <= daddr_next;
      dwdata_r     <= dwdata_next;
      rdata_r      <= rdata_next;
      rd_r         <= rd_next;
      load_valid_r <= load_valid_next;
      fault_r      <= fault_next;
    end
  end

  // The pipeline advances in the ACK cycle, so STALL drops combinationally with ACK
  assign bus.stall      = accept | ((state == ACCESS) & ~bus.dmem_ack);
  assign bus.dmem_req   = req_r;
  assign bus.dmem_we    = we_r;
  assign bus.dmem_be    = be_r;
  assign bus.dmem_addr  = daddr_r;
  assign bus.dmem_wdata = dwdata_r;
  assign bus.rdata_out  = rdata_r;
  assign bus.rd_out     = rd_r;
  assign bus.load_valid = load_valid_r;
  assign bus.fault      = fault_r;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: request and load-result scoreboards
// filled at stimulus time, drained by a monitor sampling on the falling edge.
module tb_load_store_unit;

  localparam int TIMEOUT = 16;

  typedef struct {
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_exp_t;

  typedef struct {
    logic [31:0] data;
    logic [4:0]  rd;
  } load_exp_t;

  logic clk = 1'b0;
  logic reset;
  int   errors = 0;
  int   checks = 0;
  logic req_prev = 1'b0;

  req_exp_t  req_q[$];
  load_exp_t load_q[$];

  always #5 clk = ~clk;

  load_store_unit_if bus ();

  load_store_unit #(.TIMEOUT(TIMEOUT), .CNT_W(5)) dut (
    .CLK   (clk),
    .RESET (reset),
    .bus   (bus)
  );

  // ---------------- reference model ----------------
  function automatic logic [3:0] exp_be(input logic we, input logic [2:0] f3, input logic [1:0] off);
    if (!we) return 4'b1111;
    case (f3)
      3'b000:  return 4'(1 << off);
      3'b001:  return off[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] exp_wd(input logic [2:0] f3, input logic [31:0] w);
    case (f3)
      3'b000:  return {w[7:0], w[7:0], w[7:0], w[7:0]};
      3'b001:  return {w[15:0], w[15:0]};
      default: return w;
    endcase
  endfunction

  function automatic logic [31:0] exp_ld(input logic [2:0] f3, input logic [1:0] off, input logic [31:0] word);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[8*off +: 8];
    h = off[1] ? word[31:16] : word[15:0];
    case (f3)
      3'b000:  return {{24{b[7]}}, b};
      3'b001:  return {{16{h[15]}}, h};
      3'b100:  return {24'd0, b};
      3'b101:  return {16'd0, h};
      default: return word;
    endcase
  endfunction

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (bus.dmem_req === 1'b1 && !req_prev) begin
      checks++;
      if (req_q.size() == 0) begin
        errors++;
        $display("FAIL req_unexpected: got addr=%h we=%b be=%b, required no request", bus.dmem_addr, bus.dmem_we, bus.dmem_be);
      end else begin
        req_exp_t e;
        e = req_q.pop_front();
        if (bus.dmem_we !== e.we || bus.dmem_be !== e.be || bus.dmem_addr !== e.addr ||
            (e.we && bus.dmem_wdata !== e.wdata)) begin
          errors++;
          $display("FAIL req_fields: got we=%b be=%b addr=%h wdata=%h, required we=%b be=%b addr=%h wdata=%h",
                   bus.dmem_we, bus.dmem_be, bus.dmem_addr, bus.dmem_wdata, e.we, e.be, e.addr, e.wdata);
        end
      end
    end
    req_prev = (bus.dmem_req === 1'b1);

    if (bus.load_valid === 1'b1) begin
      checks++;
      if (load_q.size() == 0) begin
        errors++;
        $display("FAIL load_unexpected: got rdata=%h rd=%0d, required no LOAD_VALID", bus.rdata_out, bus.rd_out);
      end else begin
        load_exp_t l;
        l = load_q.pop_front();
        if (bus.rdata_out !== l.data || bus.rd_out !== l.rd) begin
          errors++;
          $display("FAIL load_data: got rdata=%h rd=%0d, required rdata=%h rd=%0d", bus.rdata_out, bus.rd_out, l.data, l.rd);
        end
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_req(input logic wr_en, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] w);
    req_exp_t e;
    e.we    = wr_en;
    e.be    = exp_be(wr_en, f3, a[1:0]);
    e.addr  = {a[31:2], 2'b00};
    e.wdata = exp_wd(f3, w);
    req_q.push_back(e);
  endtask

  task automatic drive(input logic rd_en, input logic wr_en, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] w, input logic [4:0] rdi);
    bus.valid_in = 1'b1;
    bus.memread  = rd_en;
    bus.memwrite = wr_en;
    bus.funct3   = f3;
    bus.addr     = a;
    bus.wdata    = w;
    bus.rd_in    = rdi;
  endtask

  task automatic idle();
    bus.valid_in = 1'b0;
    bus.memread  = 1'b0;
    bus.memwrite = 1'b0;
    step();
    checks++;
    if (bus.load_valid !== 1'b0 || bus.dmem_req !== 1'b0) begin
      errors++;
      $display("FAIL idle_quiet: got load_valid=%b req=%b, required 0 0", bus.load_valid, bus.dmem_req);
    end
  endtask

  // One legal access, acknowledged on ACCESS cycle ack_at; leaves inputs driven.
  task automatic do_access(input logic rd_en, input logic wr_en, input logic [2:0] f3,
                           input logic [31:0] a, input logic [31:0] w, input logic [4:0] rdi,
                           input logic [31:0] mrd, input int ack_at);
    int n;
    load_exp_t l;
    push_req(wr_en, f3, a, w);
    if (!wr_en) begin
      l.data = exp_ld(f3, a[1:0], mrd);
      l.rd   = rdi;
      load_q.push_back(l);
    end
    drive(rd_en, wr_en, f3, a, w, rdi);
    n = 0;
    #1 if (bus.stall === 1'b1) n++;
    step();
    checks++;
    if (bus.load_valid !== 1'b0 || bus.dmem_req !== 1'b1) begin
      errors++;
      $display("FAIL access_start: got load_valid=%b req=%b, required 0 1", bus.load_valid, bus.dmem_req);
    end
    for (int k = 1; k <= ack_at; k++) begin
      if (k == ack_at) begin
        bus.dmem_ack   = 1'b1;
        bus.dmem_rdata = mrd;
      end else begin
        bus.dmem_rdata = $urandom;
      end
      #1 if (bus.stall === 1'b1) n++;
      step();
      bus.dmem_ack = 1'b0;
    end
    checks++;
    if (n != ack_at) begin
      errors++;
      $display("FAIL stall_cycles: got %0d, required %0d", n, ack_at);
    end
    checks++;
    if (bus.load_valid !== !wr_en || bus.dmem_req !== 1'b0) begin
      errors++;
      $display("FAIL access_end: got load_valid=%b req=%b, required %b 0", bus.load_valid, bus.dmem_req, !wr_en);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1;
    bus.valid_in = 1'b0; bus.memread = 1'b0; bus.memwrite = 1'b0;
    bus.funct3 = '0; bus.addr = '0; bus.wdata = '0; bus.rd_in = '0;
    bus.dmem_rdata = '0; bus.dmem_ack = 1'b0;
    repeat (2) step();
    checks++;
    if (bus.dmem_req !== 1'b0 || bus.dmem_we !== 1'b0 || bus.dmem_be !== 4'b0 || bus.dmem_addr !== 32'h0 ||
        bus.dmem_wdata !== 32'h0) begin
      errors++;
      $display("FAIL reset_dmem: got req=%b we=%b be=%b addr=%h wdata=%h, required all zero",
               bus.dmem_req, bus.dmem_we, bus.dmem_be, bus.dmem_addr, bus.dmem_wdata);
    end
    checks++;
    if (bus.rdata_out !== 32'h0 || bus.rd_out !== 5'd0 || bus.load_valid !== 1'b0 || bus.fault !== 1'b0 ||
        bus.stall !== 1'b0) begin
      errors++;
      $display("FAIL reset_pipe: got rdata=%h rd=%0d lv=%b fault=%b stall=%b, required all zero",
               bus.rdata_out, bus.rd_out, bus.load_valid, bus.fault, bus.stall);
    end
    reset = 1'b0;
  endtask

  task automatic test_lw();
    do_access(1'b1, 1'b0, 3'b010, 32'h0000_1004, 32'h0, 5'd7, 32'hDEAD_BEEF, 3);
    idle();
  endtask

  task automatic test_load_ext();
    do_access(1'b1, 1'b0, 3'b000, 32'h1003, 32'h0, 5'd3,  32'h8012_3456, 1);
    idle();
    do_access(1'b1, 1'b0, 3'b100, 32'h1003, 32'h0, 5'd4,  32'h8012_3456, 2);
    idle();
    do_access(1'b1, 1'b0, 3'b101, 32'h1002, 32'h0, 5'd5,  32'h8012_3456, 1);
    idle();
    do_access(1'b1, 1'b0, 3'b001, 32'h1002, 32'h0, 5'd6,  32'h8012_3456, 1);
    idle();
    do_access(1'b1, 1'b0, 3'b000, 32'h1001, 32'h0, 5'd31, 32'h8012_3456, 1);
    idle();
  endtask

  task automatic test_store();
    do_access(1'b0, 1'b1, 3'b000, 32'h2001, 32'h0000_00A5, 5'd1, 32'h0, 2);
    idle();
    do_access(1'b0, 1'b1, 3'b001, 32'h2002, 32'h0000_1234, 5'd1, 32'h0, 1);
    idle();
    // both MEMREAD and MEMWRITE: treated as a store
    do_access(1'b1, 1'b1, 3'b010, 32'h2004, 32'hCAFE_F00D, 5'd2, 32'h0, 1);
    idle();
  endtask

  task automatic test_fault();
    logic [2:0]  f3s[5]  = '{3'b010, 3'b011, 3'b001, 3'b010, 3'b100};
    logic [31:0] adrs[5] = '{32'h1002, 32'h1000, 32'h1001, 32'h2003, 32'h2000};
    logic        wrs[5]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    for (int i = 0; i < 5; i++) begin
      drive(!wrs[i], wrs[i], f3s[i], adrs[i], 32'h5555_AAAA, 5'd9);
      #1;
      checks++;
      if (bus.stall !== 1'b0) begin
        errors++;
        $display("FAIL fault_stall[%0d]: got %b, required 0", i, bus.stall);
      end
      step();
      bus.valid_in = 1'b0;
      checks++;
      if (bus.fault !== 1'b1 || bus.dmem_req !== 1'b0) begin
        errors++;
        $display("FAIL fault_pulse[%0d]: got fault=%b req=%b, required 1 0", i, bus.fault, bus.dmem_req);
      end
      step();
      checks++;
      if (bus.fault !== 1'b0) begin
        errors++;
        $display("FAIL fault_width[%0d]: got %b, required 0", i, bus.fault);
      end
    end
    // No operation: valid without read/write, and read without valid
    drive(1'b0, 1'b0, 3'b010, 32'h1000, 32'h0, 5'd1);
    #1;
    checks++;
    if (bus.stall !== 1'b0) begin
      errors++;
      $display("FAIL noop_stall: got %b, required 0", bus.stall);
    end
    step();
    bus.valid_in = 1'b0; bus.memread = 1'b1;
    #1;
    checks++;
    if (bus.stall !== 1'b0) begin
      errors++;
      $display("FAIL novalid_stall: got %b, required 0", bus.stall);
    end
    step();
    checks++;
    if (bus.dmem_req !== 1'b0 || bus.fault !== 1'b0) begin
      errors++;
      $display("FAIL noop_quiet: got req=%b fault=%b, required 0 0", bus.dmem_req, bus.fault);
    end
    idle();
  endtask

  task automatic test_timeout();
    int n;
    push_req(1'b0, 3'b010, 32'h3000, 32'h0);
    drive(1'b1, 1'b0, 3'b010, 32'h3000, 32'h0, 5'd12);
    step();
    n = 0;
    while (bus.dmem_req === 1'b1 && n < 40) begin
      n++;
      #1;
      if (bus.stall !== 1'b1) begin
        checks++;
        errors++;
        $display("FAIL timeout_stall: got %b at access cycle %0d, required 1", bus.stall, n);
      end
      step();
    end
    bus.valid_in = 1'b0;
    checks++;
    if (n != TIMEOUT) begin
      errors++;
      $display("FAIL timeout_len: got %0d request cycles, required %0d", n, TIMEOUT);
    end
    checks++;
    if (bus.fault !== 1'b1 || bus.load_valid !== 1'b0) begin
      errors++;
      $display("FAIL timeout_fault: got fault=%b lv=%b, required 1 0", bus.fault, bus.load_valid);
    end
    bus.dmem_ack = 1'b1;
    bus.dmem_rdata = 32'h7777_7777;
    step();
    bus.dmem_ack = 1'b0;
    checks++;
    if (bus.fault !== 1'b0 || bus.load_valid !== 1'b0 || bus.dmem_req !== 1'b0) begin
      errors++;
      $display("FAIL timeout_late_ack: got fault=%b lv=%b req=%b, required 0 0 0", bus.fault, bus.load_valid, bus.dmem_req);
    end
    idle();
  endtask

  task automatic test_reset_mid();
    push_req(1'b0, 3'b010, 32'h1008, 32'h0);
    drive(1'b1, 1'b0, 3'b010, 32'h1008, 32'h0, 5'd8);
    step();
    step();
    reset = 1'b1;
    bus.valid_in = 1'b0;
    step();
    reset = 1'b0;
    bus.dmem_ack = 1'b1;
    bus.dmem_rdata = 32'h1111_1111;
    #1;
    checks++;
    if (bus.dmem_req !== 1'b0 || bus.load_valid !== 1'b0 || bus.fault !== 1'b0 || bus.stall !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: got req=%b lv=%b fault=%b stall=%b, required 0 0 0 0",
               bus.dmem_req, bus.load_valid, bus.fault, bus.stall);
    end
    step();
    bus.dmem_ack = 1'b0;
    checks++;
    if (bus.dmem_req !== 1'b0 || bus.load_valid !== 1'b0 || bus.fault !== 1'b0) begin
      errors++;
      $display("FAIL reset_late_ack: got req=%b lv=%b fault=%b, required 0 0 0", bus.dmem_req, bus.load_valid, bus.fault);
    end
    do_access(1'b1, 1'b0, 3'b010, 32'h100C, 32'h0, 5'd9, 32'h0BAD_F00D, 2);
    idle();
  endtask

  task automatic test_back_to_back();
    do_access(1'b1, 1'b0, 3'b010, 32'h4000, 32'h0,         5'd10, 32'h0102_0304, 1);
    do_access(1'b0, 1'b1, 3'b010, 32'h4004, 32'h89AB_CDEF, 5'd0,  32'h0,         1);
    do_access(1'b1, 1'b0, 3'b101, 32'h4006, 32'h0,         5'd11, 32'hF00D_8001, 2);
    do_access(1'b1, 1'b0, 3'b000, 32'h4002, 32'h0,         5'd13, 32'h00C3_0000, 1);
    idle();
  endtask

  initial begin
    test_reset();
    test_lw();
    test_load_ext();
    test_store();
    test_fault();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    repeat (2) step();
    checks++;
    if (req_q.size() != 0 || load_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d requests and %0d loads outstanding, required 0 0", req_q.size(), load_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
